if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-003 stall  input  1  hazard stall from decode; 1 = hold PC and IF/ID.
REQ-004 br_taken  input  1  redirect request from decode; 1 = load br_target into PC.
REQ-005 br_target  input  32  redirect byte address.
REQ-006 ifid_flush  input  1  1 = load NOP into IF/ID on the next edge.
REQ-007 im_addr  output  32  byte address presented to the instruction memory; equals the PC.
REQ-008 im_data  input  32  instruction word returned combinationally by the instruction memory for im_addr.
REQ-009 ifid_instr  output  32  registered instruction handed to decode.
REQ-010 ifid_pc  output  32  registered address of ifid_instr.
REQ-011 ifid_pc8  output  32  registered ifid_pc+8, the link value.
REQ-012 ifid_valid  output  1  1 = IF/ID holds a fetched instruction; 0 = bubble.
REQ-013 addr_err  output  1  sticky fetch-range error flag.

Function
REQ-014 The PC SHALL be a 32-bit register, and im_addr SHALL equal the PC combinationally, with zero latency.
REQ-015 PC next-state priority SHALL be: reset, then stall (hold), then br_taken (load {br_target[31:2],2'b00}), then PC+4.
REQ-016 br_taken SHALL be ignored in any cycle where stall=1; decode re-asserts it once the stall clears.
REQ-017 PC+4 SHALL be modulo 2^32: 0xFFFFFFFC SHALL be followed by 0x00000000.
REQ-018 IF/ID next-state priority SHALL be: reset, then ifid_flush, then stall (hold), then capture.
REQ-019 Capture SHALL load ifid_instr=im_data, ifid_pc=PC, ifid_pc8=PC+8 (mod 2^32) and ifid_valid=1.
REQ-020 Flush SHALL load ifid_instr=0x00000000 and ifid_valid=0; ifid_pc and ifid_pc8 SHALL hold.
REQ-021 br_taken SHALL NOT flush IF/ID: the instruction in IF when the branch resolves is the delay slot and SHALL be captured normally.
REQ-022 When ifid_flush=1 and stall=1 in the same cycle, the flush SHALL win for IF/ID and the stall SHALL win for the PC.
REQ-023 Fetch latency SHALL be one cycle: the instruction at PC appears on ifid_instr after the next rising edge.

Reset
REQ-024 With reset=0 at an edge, the PC SHALL become 0x00003000.
REQ-025 With reset=0 at an edge, ifid_instr, ifid_pc and ifid_pc8 SHALL become 0 and ifid_valid SHALL become 0.
REQ-026 With reset=0 at an edge, addr_err SHALL become 0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL override both; the first post-reset fetch SHALL be from 0x00003000.
REQ-028 reset SHALL have no effect between edges.

Configuration
REQ-029 Macro IF_ADDR_CHECK_EN: when defined, a capture with PC outside 0x00003000..0x00004FFC, or with PC[1:0]!=0, SHALL load ifid_instr=0x00000000 with ifid_valid=1.
REQ-030 Under IF_ADDR_CHECK_EN, the same out-of-range or misaligned capture SHALL set addr_err=1, and addr_err SHALL stay 1 until reset.
REQ-031 When IF_ADDR_CHECK_EN is undefined, addr_err SHALL be constant 0 and no range or alignment checking SHALL exist.

Verification
REQ-032 Release reset, no stall, IM word[k]=k: im_addr steps 0x3000, 0x3004, 0x3008; after 2 edges ifid_instr=1, ifid_pc=0x3004, ifid_pc8=0x300C, ifid_valid=1.
REQ-033 PC=0x3010, br_taken=1, br_target=0x3042 for one cycle: next PC=0x3040; IF/ID captures the 0x3010 word (delay slot, not flushed).
REQ-034 stall=1 and br_taken=1 for 2 cycles, then stall=0 and br_taken=1: PC and IF/ID hold for 2 cycles, then PC=target.
REQ-035 ifid_flush=1 with stall=1: ifid_instr=0 and ifid_valid=0 next cycle, PC unchanged; force PC to 0xFFFFFFFC via redirect: next PC=0x00000000.
REQ-036 IF_ADDR_CHECK_EN defined, redirect to 0x00005000: capture gives ifid_instr=0 and addr_err=1, still 1 after 10 cycles, 0 after reset; with the macro undefined, addr_err=0 throughout.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, redirect/stall handling and the IF/ID pipeline register.
// Optional fetch range/alignment checking is enabled by defining IF_ADDR_CHECK_EN.
module if_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ifid_flush,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc8,
  output logic        ifid_valid,
  output logic        addr_err
);

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic [31:0] pc;

  assign im_addr = pc;

  // A taken branch only retargets the PC; the word already in IF is the delay slot.
  always_ff @(posedge clk) begin
    if (!reset)        pc <= PC_RESET;
    else if (!stall) begin
      if (br_taken)    pc <= {br_target[31:2], 2'b00};
      else             pc <= pc + 32'd4;
    end
  end

`ifdef IF_ADDR_CHECK_EN
  logic bad_addr;
  logic err_q;

  assign bad_addr = (pc < 32'h0000_3000) || (pc > 32'h0000_4FFC) || (pc[1:0] != 2'b00);
  assign addr_err = err_q;

  always_ff @(posedge clk) begin
    if (!reset)                                 err_q <= 1'b0;
    else if (!ifid_flush && !stall && bad_addr) err_q <= 1'b1;
  end
`else
  assign addr_err = 1'b0;
`endif

  // Flush beats stall here, while the PC still honours the stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ifid_instr <= 32'h0;
      ifid_pc    <= 32'h0;
      ifid_pc8   <= 32'h0;
      ifid_valid <= 1'b0;
    end else if (ifid_flush) begin
      ifid_instr <= 32'h0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
`ifdef IF_ADDR_CHECK_EN
      ifid_instr <= bad_addr ? 32'h0 : im_data;
`else
      ifid_instr <= im_data;
`endif
      ifid_pc    <= pc;
      ifid_pc8   <= pc + 32'd8;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, hand-written corner sequences,
// then randomized traffic against a rule-level reference model.
module tb_if_fetch;

`ifdef IF_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, ifid_flush;
  logic [31:0] br_target, im_addr, im_data;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc8;
  logic        ifid_valid, addr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // IM holds word index k at byte address 0x3000 + 4k (wraps for other addresses).
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a - 32'h3000) >> 2;
  endfunction

  assign im_data = word(im_addr);

  if_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .ifid_flush(ifid_flush), .im_addr(im_addr), .im_data(im_data), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc8(ifid_pc8), .ifid_valid(ifid_valid), .addr_err(addr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stl, br, fl;
    logic [31:0] tgt;
    logic [31:0] pc, instr, ipc, pc8;
    logic        vld, err;
  } vec_t;

  function automatic vec_t mk(input logic rst, stl, br, fl, input logic [31:0] tgt,
                              input logic [31:0] pc, instr, ipc, pc8, input logic vld, err);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.fl = fl; v.tgt = tgt;
    v.pc = pc; v.instr = instr; v.ipc = ipc; v.pc8 = pc8; v.vld = vld; v.err = err;
    return v;
  endfunction

  // Drive at negedge, clock through posedge, sample at the following negedge.
  task automatic cycle(input logic rst, stl, br, fl, input logic [31:0] tgt);
    reset = rst; stall = stl; br_taken = br; ifid_flush = fl; br_target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, instr, ipc, pc8,
                         input logic vld, err);
    chk({tag, " im_addr"}, im_addr, pc);
    chk({tag, " ifid_instr"}, ifid_instr, instr);
    chk({tag, " ifid_pc"}, ifid_pc, ipc);
    chk({tag, " ifid_pc8"}, ifid_pc8, pc8);
    chk({tag, " ifid_valid"}, {31'b0, ifid_valid}, {31'b0, vld});
    chk({tag, " addr_err"}, {31'b0, addr_err}, {31'b0, err});
  endtask

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_pc8;
  logic        m_vld, m_err;

  task automatic model_step(input logic rst, stl, br, fl, input logic [31:0] tgt);
    logic bad;
    if (!rst) begin
      m_pc = 32'h3000; m_instr = 0; m_ipc = 0; m_pc8 = 0; m_vld = 0; m_err = 0;
    end else begin
      if (fl) begin
        m_instr = 0; m_vld = 0;
      end else if (!stl) begin
        bad = CHK && (m_pc < 32'h3000 || m_pc > 32'h4FFC || m_pc % 4 != 0);
        m_instr = bad ? 32'h0 : word(m_pc);
        m_ipc = m_pc; m_pc8 = m_pc + 8; m_vld = 1;
        if (bad) m_err = 1;
      end
      if (!stl) m_pc = br ? (tgt & ~32'h3) : m_pc + 4;
    end
  endtask

  vec_t tbl[16];

  initial begin
    logic [31:0] prev_pc;
    logic        r, s, b, f;
    logic [31:0] t;

    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; ifid_flush = 1'b0; br_target = 32'h0;

    //            rst stl br fl  tgt            pc             instr                    ipc            pc8            vld err
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,        32'h3000,      32'h0,                   32'h0,         32'h0,         0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h0,        32'h3004,      32'h0,                   32'h3000,      32'h3008,      1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 32'h0,        32'h3008,      32'h1,                   32'h3004,      32'h300C,      1, 0);
    tbl[3]  = mk(1, 0, 0, 0, 32'h0,        32'h300C,      32'h2,                   32'h3008,      32'h3010,      1, 0);
    tbl[4]  = mk(1, 0, 0, 0, 32'h0,        32'h3010,      32'h3,                   32'h300C,      32'h3014,      1, 0);
    tbl[5]  = mk(1, 0, 1, 0, 32'h3042,     32'h3040,      32'h4,                   32'h3010,      32'h3018,      1, 0);
    tbl[6]  = mk(1, 1, 1, 0, 32'h3100,     32'h3040,      32'h4,                   32'h3010,      32'h3018,      1, 0);
    tbl[7]  = mk(1, 1, 1, 0, 32'h3100,     32'h3040,      32'h4,                   32'h3010,      32'h3018,      1, 0);
    tbl[8]  = mk(1, 0, 1, 0, 32'h3100,     32'h3100,      32'h10,                  32'h3040,      32'h3048,      1, 0);
    tbl[9]  = mk(1, 1, 0, 1, 32'h0,        32'h3100,      32'h0,                   32'h3040,      32'h3048,      0, 0);
    tbl[10] = mk(1, 0, 0, 1, 32'h0,        32'h3104,      32'h0,                   32'h3040,      32'h3048,      0, 0);
    tbl[11] = mk(1, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFC,  32'h41,                  32'h3104,      32'h310C,      1, 0);
    tbl[12] = mk(1, 0, 0, 0, 32'h0,        32'h0,         CHK ? 32'h0 : 32'h3FFFF3FF, 32'hFFFFFFFC, 32'h4,      1, CHK);
    tbl[13] = mk(1, 0, 0, 0, 32'h0,        32'h4,         CHK ? 32'h0 : 32'h3FFFF400, 32'h0,        32'h8,      1, CHK);
    tbl[14] = mk(0, 1, 1, 0, 32'h5000,     32'h3000,      32'h0,                   32'h0,         32'h0,         0, 0);
    tbl[15] = mk(1, 0, 0, 0, 32'h0,        32'h3004,      32'h0,                   32'h3000,      32'h3008,      1, 0);

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].rst, tbl[i].stl, tbl[i].br, tbl[i].fl, tbl[i].tgt);
      chk_all($sformatf("row%0d", i), tbl[i].pc, tbl[i].instr, tbl[i].ipc, tbl[i].pc8,
              tbl[i].vld, tbl[i].err);
    end

    // Reset pulsed between edges must be ignored.
    prev_pc = im_addr;
    reset = 1'b0; #2 reset = 1'b1;
    cycle(1, 0, 0, 0, 32'h0);
    chk("glitch reset pc", im_addr, prev_pc + 32'd4);

    // Redirect out of range: sticky error under the check, silent otherwise.
    cycle(1, 0, 1, 0, 32'h5000);
    chk("oor redirect pc", im_addr, 32'h5000);
    cycle(1, 0, 0, 0, 32'h0);
    chk("oor instr", ifid_instr, CHK ? 32'h0 : 32'h800);
    chk("oor valid", {31'b0, ifid_valid}, 32'h1);
    chk("oor err", {31'b0, addr_err}, {31'b0, CHK});
    for (int i = 0; i < 10; i++) cycle(1, 0, (i == 3), 0, 32'h3000);
    chk("oor err sticky", {31'b0, addr_err}, {31'b0, CHK});
    cycle(0, 0, 0, 0, 32'h0);
    chk("err after reset", {31'b0, addr_err}, 32'h0);
    chk("pc after reset", im_addr, 32'h3000);

    // Randomized traffic against the model, synced by the reset just applied.
    model_step(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 5) == 0);
      t = $urandom_range(0, 1) ? 32'h3000 + $urandom_range(0, 32'h2100) : $urandom;
      chk($sformatf("rnd%0d im_addr pre", i), im_addr, m_pc);
      model_step(r, s, b, f, t);
      cycle(r, s, b, f, t);
      chk_all($sformatf("rnd%0d", i), m_pc, m_instr, m_ipc, m_pc8, m_vld, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
